// File: rtl/is_issue_ctrl.sv
// In-order dual-issue scheduler between the DS/IS register and the two ALU
// ports. Tracks physical-register readiness in a busy scoreboard cleared by
// writeback wakeups, decides which IS-stage instructions fire each cycle, and
// holds the DS/IS register while inst2 is pending.
module is_issue_ctrl #(
  parameter int NPHY = 64,
  parameter int PW   = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          is_i1_valid,
  input  logic [PW-1:0] is_i1_src1,
  input  logic [PW-1:0] is_i1_src2,
  input  logic [PW-1:0] is_i1_dst,
  input  logic          is_i2_valid,
  input  logic [PW-1:0] is_i2_src1,
  input  logic [PW-1:0] is_i2_src2,
  input  logic [PW-1:0] is_i2_dst,
  input  logic          wb0_valid,
  input  logic [PW-1:0] wb0_tag,
  input  logic          wb1_valid,
  input  logic [PW-1:0] wb1_tag,
  output logic          i1_fire,
  output logic          i2_fire,
  output logic          stall,
  output logic          half_issued,
  output logic [31:0]   stall_cnt
);

  typedef enum logic {BOTH, I2_ONLY} state_t;

  state_t          state, state_nxt;
  logic [NPHY-1:0] busy, busy_nxt;
  logic            i1_ok, i2_ok, raw, i1_done, i2_done;

  // Operand readiness with same-cycle writeback bypass; tag 0 is always ready.
  function automatic logic rdy(input logic [PW-1:0] p, input logic [NPHY-1:0] b,
                               input logic w0v, input logic [PW-1:0] w0t,
                               input logic w1v, input logic [PW-1:0] w1t);
    return (p == '0) | ~b[p] | (w0v & (w0t == p)) | (w1v & (w1t == p));
  endfunction

  // Source readiness and the intra-pair RAW hazard.
  always_comb begin
    i1_ok = rdy(is_i1_src1, busy, wb0_valid, wb0_tag, wb1_valid, wb1_tag) &
            rdy(is_i1_src2, busy, wb0_valid, wb0_tag, wb1_valid, wb1_tag);
    i2_ok = rdy(is_i2_src1, busy, wb0_valid, wb0_tag, wb1_valid, wb1_tag) &
            rdy(is_i2_src2, busy, wb0_valid, wb0_tag, wb1_valid, wb1_tag);
    raw   = (is_i1_dst != '0) &
            ((is_i2_src1 == is_i1_dst) | (is_i2_src2 == is_i1_dst));
  end

  // Issue decision, stall and next state; reset and flush force all quiet.
  always_comb begin
    i1_fire   = 1'b0;
    i2_fire   = 1'b0;
    stall     = 1'b0;
    i1_done   = 1'b0;
    i2_done   = 1'b0;
    state_nxt = state;
    if (!rst && !flush) begin
      unique case (state)
        BOTH: begin
          i1_fire   = is_i1_valid & i1_ok;
          i1_done   = ~is_i1_valid | i1_fire;
          i2_fire   = is_i2_valid & i1_done & i2_ok & ~(i1_fire & raw);
          i2_done   = ~is_i2_valid | i2_fire;
          stall     = ~(i1_done & i2_done);
          state_nxt = (is_i1_valid & i1_fire & ~i2_done) ? I2_ONLY : BOTH;
        end
        I2_ONLY: begin
          // inst1 already issued, so its dst is busy and RAW is covered by
          // the scoreboard; a missing inst2 just releases the pair.
          if (!is_i2_valid) begin
            state_nxt = BOTH;
          end else begin
            i2_fire   = i2_ok;
            stall     = ~i2_ok;
            state_nxt = i2_ok ? BOTH : I2_ONLY;
          end
        end
        default: state_nxt = BOTH;
      endcase
    end
  end

  assign half_issued = ~rst & (state == I2_ONLY);

  // Scoreboard next value: wakeups clear first, issues set afterwards.
  always_comb begin
    busy_nxt = busy;
    if (wb0_valid) busy_nxt[wb0_tag] = 1'b0;
    if (wb1_valid) busy_nxt[wb1_tag] = 1'b0;
    if (i1_fire && is_i1_dst != '0) busy_nxt[is_i1_dst] = 1'b1;
    if (i2_fire && is_i2_dst != '0) busy_nxt[is_i2_dst] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // State and scoreboard registers.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= BOTH;
      busy  <= '0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
    end
  end

  // Stall-cycle counter; survives flush, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst)        stall_cnt <= '0;
    else if (stall) stall_cnt <= stall_cnt + 32'd1;
  end

endmodule

// File: tb/tb_is_issue_ctrl.sv
// Directed bench for is_issue_ctrl: inputs change 1ns after posedge, outputs
// are compared at negedge against hand-computed values.
module tb_is_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst, flush;
  logic       is_i1_valid, is_i2_valid, wb0_valid, wb1_valid;
  logic [5:0] is_i1_src1, is_i1_src2, is_i1_dst;
  logic [5:0] is_i2_src1, is_i2_src2, is_i2_dst;
  logic [5:0] wb0_tag, wb1_tag;
  logic       i1_fire, i2_fire, stall, half_issued;
  logic [31:0] stall_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  is_issue_ctrl #(.NPHY(64), .PW(6)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .is_i1_valid(is_i1_valid), .is_i1_src1(is_i1_src1), .is_i1_src2(is_i1_src2), .is_i1_dst(is_i1_dst),
    .is_i2_valid(is_i2_valid), .is_i2_src1(is_i2_src1), .is_i2_src2(is_i2_src2), .is_i2_dst(is_i2_dst),
    .wb0_valid(wb0_valid), .wb0_tag(wb0_tag), .wb1_valid(wb1_valid), .wb1_tag(wb1_tag),
    .i1_fire(i1_fire), .i2_fire(i2_fire), .stall(stall),
    .half_issued(half_issued), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_i1(input logic v, input logic [5:0] s1, input logic [5:0] s2, input logic [5:0] d);
    is_i1_valid = v; is_i1_src1 = s1; is_i1_src2 = s2; is_i1_dst = d;
  endtask

  task automatic set_i2(input logic v, input logic [5:0] s1, input logic [5:0] s2, input logic [5:0] d);
    is_i2_valid = v; is_i2_src1 = s1; is_i2_src2 = s2; is_i2_dst = d;
  endtask

  task automatic set_wb(input logic v0, input logic [5:0] t0, input logic v1, input logic [5:0] t1);
    wb0_valid = v0; wb0_tag = t0; wb1_valid = v1; wb1_tag = t1;
  endtask

  // Compare the combinational outputs at the negedge of the current cycle.
  task automatic expect_out(input string tag, input logic f1, input logic f2,
                            input logic st, input logic hi);
    @(negedge clk);
    chk({tag, ".i1_fire"}, 32'(i1_fire), 32'(f1));
    chk({tag, ".i2_fire"}, 32'(i2_fire), 32'(f2));
    chk({tag, ".stall"},   32'(stall),   32'(st));
    chk({tag, ".half"},    32'(half_issued), 32'(hi));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    set_i1(1'b1, 6'd0, 6'd0, 6'd0);
    set_i2(1'b1, 6'd0, 6'd0, 6'd0);
    set_wb(1'b0, 6'd0, 1'b0, 6'd0);
    tick(); tick();
    expect_out("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.cnt", stall_cnt, 32'd0);
    tick();
    rst = 1'b0;

    // Independent pair, all ready
    set_i1(1'b1, 6'd3, 6'd4, 6'd10); set_i2(1'b1, 6'd5, 6'd6, 6'd11);
    expect_out("pair", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    // Tag 10 now busy
    set_i1(1'b1, 6'd10, 6'd0, 6'd0); set_i2(1'b0, 6'd0, 6'd0, 6'd0);
    expect_out("busy10", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    set_wb(1'b1, 6'd10, 1'b1, 6'd11);
    expect_out("wake10", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("wake10.cnt", stall_cnt, 32'd1);
    tick();

    // Intra-pair RAW: i2 src1 = i1 dst = 10
    set_wb(1'b0, 6'd0, 1'b0, 6'd0);
    set_i1(1'b1, 6'd1, 6'd2, 6'd10); set_i2(1'b1, 6'd10, 6'd5, 6'd13);
    expect_out("raw.c0", 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    expect_out("raw.c1", 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    set_wb(1'b1, 6'd10, 1'b0, 6'd0);
    expect_out("raw.c2", 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    set_wb(1'b1, 6'd13, 1'b0, 6'd0);
    set_i1(1'b0, 6'd0, 6'd0, 6'd0); set_i2(1'b0, 6'd0, 6'd0, 6'd0);
    expect_out("raw.done", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("raw.cnt", stall_cnt, 32'd3);
    tick();

    // i1 blocked on busy 7 blocks i2 too; wb1 wakeup releases both
    set_wb(1'b0, 6'd0, 1'b0, 6'd0);
    set_i1(1'b1, 6'd0, 6'd0, 6'd7);
    expect_out("set7", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_i1(1'b1, 6'd7, 6'd0, 6'd8); set_i2(1'b1, 6'd1, 6'd2, 6'd9);
    expect_out("blk7", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    set_wb(1'b0, 6'd0, 1'b1, 6'd7);
    expect_out("wake7", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("wake7.cnt", stall_cnt, 32'd4);
    tick();
    set_wb(1'b1, 6'd8, 1'b1, 6'd9);
    set_i1(1'b0, 6'd0, 6'd0, 6'd0); set_i2(1'b0, 6'd0, 6'd0, 6'd0);
    tick();

    // Lone i2, then empty slot
    set_wb(1'b0, 6'd0, 1'b0, 6'd0);
    set_i2(1'b1, 6'd1, 6'd2, 6'd0);
    expect_out("i2only", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    set_i2(1'b0, 6'd0, 6'd0, 6'd0);
    expect_out("empty", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Flush while half-issued with busy 20
    set_i1(1'b1, 6'd0, 6'd0, 6'd20); set_i2(1'b1, 6'd20, 6'd0, 6'd21);
    expect_out("fl.enter", 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    flush = 1'b1;
    expect_out("fl.cyc", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    flush = 1'b0;
    set_i1(1'b1, 6'd20, 6'd0, 6'd0); set_i2(1'b0, 6'd0, 6'd0, 6'd0);
    expect_out("fl.after", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("fl.cnt", stall_cnt, 32'd5);
    tick();

    // Set beats clear on the same tag
    set_i1(1'b1, 6'd0, 6'd0, 6'd12); set_wb(1'b1, 6'd12, 1'b0, 6'd0);
    expect_out("sc.set", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_wb(1'b0, 6'd0, 1'b0, 6'd0);
    set_i1(1'b1, 6'd12, 6'd0, 6'd0);
    expect_out("sc.busy", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    set_wb(1'b1, 6'd12, 1'b1, 6'd12);
    expect_out("sc.wake", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_wb(1'b0, 6'd0, 1'b0, 6'd0);

    // Half-issued pair whose inst2 disappears
    set_i1(1'b1, 6'd0, 6'd0, 6'd30); set_i2(1'b1, 6'd30, 6'd0, 6'd31);
    expect_out("def.enter", 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    set_i1(1'b0, 6'd0, 6'd0, 6'd0); set_i2(1'b0, 6'd0, 6'd0, 6'd0);
    expect_out("def.drop", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    expect_out("def.back", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("def.cnt", stall_cnt, 32'd7);
    tick();

    // Reset mid-operation
    set_i1(1'b1, 6'd0, 6'd0, 6'd40); set_i2(1'b1, 6'd40, 6'd0, 6'd41);
    expect_out("mr.enter", 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    rst = 1'b1;
    expect_out("mr.rst", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    set_i1(1'b1, 6'd40, 6'd0, 6'd0); set_i2(1'b0, 6'd0, 6'd0, 6'd0);
    expect_out("mr.after", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("mr.cnt", stall_cnt, 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/is_issue_ctrl.md
Name: is_issue_ctrl

Overview:
- In-order dual-issue scheduler between the DS/IS pipeline register and the two ALU ports.
- Keeps a physical-register busy scoreboard, which is cleared by writeback wakeups.
- Each cycle it decides which of the two IS-stage instructions fire. When inst2 is held back, it drives the Stall signal into the DS/IS register.

Parameters:
- NPHY, 64, number of physical registers.
- PW, 6, physical tag width; NPHY must equal 2**PW.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  pipeline flush, synchronous
- is_i1_valid  in  1  inst1 present in IS stage
- is_i1_src1, is_i1_src2, is_i1_dst  in  PW each  inst1 physical sources and destination
- is_i2_valid  in  1  inst2 present in IS stage
- is_i2_src1, is_i2_src2, is_i2_dst  in  PW each  inst2 physical sources and destination
- wb0_valid, wb1_valid  in  1 each  writeback wakeup valid
- wb0_tag, wb1_tag  in  PW each  physical register written back
- i1_fire  out  1  inst1 issues to ALU port 0 this cycle
- i2_fire  out  1  inst2 issues to ALU port 1 this cycle
- stall  out  1  hold the DS/IS register this cycle
- half_issued  out  1  state is I2_ONLY
- stall_cnt  out  32  count of cycles with stall=1

Behaviour:
- Scoreboard: busy[NPHY-1:0], registered. Tag 0 is always ready and is never marked busy.
- rdy(p) = (p==0) | ~busy[p] | (wb0_valid & wb0_tag==p) | (wb1_valid & wb1_tag==p). This gives a same-cycle wakeup bypass.
- i1_ok = rdy(is_i1_src1) & rdy(is_i1_src2).
- i2_ok = rdy(is_i2_src1) & rdy(is_i2_src2).
- raw = is_i1_dst!=0 & (is_i2_src1==is_i1_dst | is_i2_src2==is_i1_dst).
- FSM states:
  - BOTH: neither instruction of the current IS pair has issued.
  - I2_ONLY: inst1 has issued; inst2 is still pending.
- BOTH (all outputs combinational):
  - i1_fire = is_i1_valid & i1_ok.
  - i1_done = ~is_i1_valid | i1_fire.
  - i2_fire = is_i2_valid & i1_done & i2_ok & ~(i1_fire & raw).
  - i2_done = ~is_i2_valid | i2_fire.
  - stall = ~(i1_done & i2_done).
  - Next state: I2_ONLY if is_i1_valid & i1_fire & ~i2_done; otherwise BOTH.
- I2_ONLY:
  - inst1 is masked (i1_fire=0).
  - i2_fire = is_i2_valid & i2_ok. The RAW check is not applied, because inst1's dst is already busy in the scoreboard.
  - stall = ~i2_fire.
  - On fire go to BOTH; otherwise stay.
  - If is_i2_valid=0 here: stall=0 and go to BOTH (defensive).
- Busy update, in order:
  - Clear bits for wb0/wb1 tags.
  - Then set bits for is_i1_dst on i1_fire and is_i2_dst on i2_fire (nonzero tags only).
  - When a set and a clear hit the same tag in one cycle, the set wins.
- Flush, highest priority below rst:
  - i1_fire=i2_fire=stall=0 in the flush cycle.
  - Next cycle: busy cleared to all 0, state BOTH. stall_cnt is not cleared.
- stall_cnt increments by 1 each cycle stall=1, wraps at 2^32-1 to 0, and holds otherwise.
- Reset (rst=1): busy=0, state=BOTH, stall_cnt=0.
  - Combinational outputs read i1_fire=0, i2_fire=0, stall=0 and half_issued=0 while rst is high.
  - rst mid-operation discards any half-issued pair.
- Latency:
  - Issue decision is zero-cycle.
  - A dependent instruction can issue in the same cycle as its producer's writeback.
- Both wb ports may carry the same tag; the result is a single clear.

Test Plan:
- Reset, then pair with i1 (src 3,4; dst 10) and i2 (src 5,6; dst 11), all ready -> i1_fire=i2_fire=1, stall=0; next cycle busy[10]=busy[11]=1.
- i2 src1=10 = i1 dst=10, all else ready -> cycle 0: i1_fire=1, i2_fire=0, stall=1, next state I2_ONLY. Cycle 1: no wb, i2 held, stall=1. Cycle 2: wb0_valid with tag 10 -> i2_fire=1 via bypass, stall=0, state BOTH; stall_cnt=2.
- busy[7]=1, i1 src1=7 -> i1_fire=0, i2_fire=0, stall=1. Then wb1_tag=7 -> both fire the same cycle.
- i1_valid=0, i2_valid=1 with ready sources -> i2_fire=1, stall=0. Both valid=0 -> no fire, stall=0.
- In I2_ONLY with busy[20]=1, assert flush -> fires=0, stall=0. Next cycle state BOTH, busy all 0, half_issued=0, stall_cnt unchanged.
- Set and clear on the same tag: i1 dst=12 fires while wb0_tag=12 -> busy[12]=1 next cycle. Tag-0 sources are always ready; dst=0 never sets busy.
